// File: rtl/func_gen_dds.sv
// func_gen_dds: phase-accumulator function generator with glitch-free config apply at phase wrap
module func_gen_dds #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [DATA_W-1:0] cfg_duty,
    input  logic [2:0]        cfg_mode,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic [DATA_W-1:0] wave_out,
    output logic              wave_valid,
    output logic              sync
);
    localparam logic [2:0] SINE = 3'd0, TRI = 3'd1, SQUARE = 3'd2, PWM = 3'd3, SAW = 3'd4;
    localparam logic [DATA_W-1:0] DUTY0 = {1'b1, {(DATA_W-1){1'b0}}};
    logic [PHASE_W-1:0] phase_q, freq_q, sfreq_q;
    logic [PHASE_W:0]   sum_d;
    logic [2:0]         mode_q, smode_q, s1_mode_q;
    logic [DATA_W-1:0]  duty_q, sduty_q, s1_duty_q, wave_d, wave_q, top_d, tri_d;
    logic [DATA_W:0]    s1_u_q;
    logic               pend_q, wrap_q, carry_d, apply_d, capture_d;
    logic               s1_v_q, s1_w_q, valid_q, sync_q;

    assign cfg_ready  = ~pend_q;
    assign tbl_addr   = phase_q[PHASE_W-1 -: ADDR_W];
    assign wave_out   = wave_q;
    assign wave_valid = valid_q;
    assign sync       = sync_q;

    // Phase add, wrap detection, config handshake decisions and waveform shaping
    always_comb begin
        sum_d     = {1'b0, phase_q} + {1'b0, freq_q};
        carry_d   = en & sum_d[PHASE_W];
        apply_d   = pend_q & (carry_d | ~en | (freq_q == '0));
        capture_d = cfg_valid & ~pend_q;
        top_d     = s1_u_q[DATA_W:1];
        tri_d     = s1_u_q[DATA_W] ? ~s1_u_q[DATA_W-1:0] : s1_u_q[DATA_W-1:0];
        wave_d    = s1_mode_q == SINE   ? tbl_data :
                    s1_mode_q == TRI    ? tri_d :
                    s1_mode_q == SQUARE ? (s1_u_q[DATA_W] ? '0 : '1) :
                    s1_mode_q == PWM    ? ((top_d < s1_duty_q) ? '1 : '0) :
                    s1_mode_q == SAW    ? top_d : '0;
    end

    // Shadow capture on handshake, active update only at a safe point
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            mode_q  <= SINE;
            freq_q  <= '0;
            duty_q  <= DUTY0;
            smode_q <= SINE;
            sfreq_q <= '0;
            sduty_q <= DUTY0;
        end else begin
            if (capture_d) begin
                smode_q <= cfg_mode;
                sfreq_q <= cfg_freq;
                sduty_q <= cfg_duty;
            end
            if (apply_d) begin
                mode_q <= smode_q;
                freq_q <= sfreq_q;
                duty_q <= sduty_q;
            end
            pend_q <= capture_d | (pend_q & ~apply_d);
        end
    end

    // Phase accumulator; wrap_q marks that phase_q holds the first post-wrap value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (en) begin
            phase_q <= sum_d[PHASE_W-1:0];
            wrap_q  <= carry_d;
        end
    end

    // S1: phase top bits plus the config that belongs to this sample, aligned with ROM read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_w_q    <= 1'b0;
            s1_u_q    <= '0;
            s1_mode_q <= SINE;
            s1_duty_q <= DUTY0;
        end else begin
            s1_v_q <= en;
            s1_w_q <= wrap_q;
            if (en) begin
                s1_u_q    <= phase_q[PHASE_W-1 -: DATA_W+1];
                s1_mode_q <= mode_q;
                s1_duty_q <= duty_q;
            end
        end
    end

    // S2: output sample register, holds its value while no new sample arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_q  <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            valid_q <= s1_v_q;
            sync_q  <= s1_v_q & s1_w_q;
            if (s1_v_q) wave_q <= wave_d;
        end
    end
endmodule

// File: tb/tb_func_gen_dds.sv
// tb_func_gen_dds: randomized and directed checks of func_gen_dds against a behavioural model
module tb_func_gen_dds;
    localparam int PW = 32, DW = 8, AW = 8;
    localparam longint unsigned MOD = 64'd1 << PW;
    logic clk = 0, rst_n = 0, en = 0, cfg_valid = 0;
    logic cfg_ready, wave_valid, sync;
    logic [PW-1:0] cfg_freq = '0;
    logic [DW-1:0] cfg_duty = '0, tbl_data, wave_out;
    logic [2:0] cfg_mode = '0;
    logic [AW-1:0] tbl_addr;
    int checks = 0, errors = 0;
    bit chk_on = 0;

    longint unsigned m_phase, m_freq, ms_freq;
    int m_mode, ms_mode, m_duty, ms_duty, s1_val, o_wave;
    bit m_wrap, m_pend, s1_v, s1_s, o_v, o_s;

    func_gen_dds #(.PHASE_W(PW), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_duty(cfg_duty), .cfg_mode(cfg_mode), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .wave_out(wave_out), .wave_valid(wave_valid), .sync(sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tbl_data <= tbl_addr ^ 8'h80;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sample(longint unsigned ph, int mode, int duty);
        int top, u;
        top = int'(ph >> (PW - DW));
        u = int'(ph >> (PW - DW - 1));
        case (mode)
            0: return int'(ph >> (PW - AW)) ^ 'h80;
            1: return (u >= 256) ? 511 - u : u;
            2: return (ph >= MOD / 2) ? 0 : 255;
            3: return (top < duty) ? 255 : 0;
            4: return top;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit carry, apply, cap;
        if (!rst_n) begin
            m_phase = 0; m_wrap = 0; m_pend = 0;
            m_mode = 0; m_freq = 0; m_duty = 128;
            s1_v = 0; s1_s = 0; o_v = 0; o_s = 0; o_wave = 0;
        end else begin
            o_v = s1_v;
            o_s = s1_v && s1_s;
            if (s1_v) o_wave = s1_val;
            s1_v = en;
            s1_s = m_wrap;
            if (en) s1_val = sample(m_phase, m_mode, m_duty);
            carry = en && (m_phase + m_freq >= MOD);
            apply = m_pend && (carry || !en || m_freq == 0);
            cap = cfg_valid && !m_pend;
            if (en) begin
                m_phase = (m_phase + m_freq) % MOD;
                m_wrap = carry;
            end
            if (apply) begin
                m_mode = ms_mode; m_freq = ms_freq; m_duty = ms_duty; m_pend = 0;
            end
            if (cap) begin
                ms_mode = int'(cfg_mode); ms_freq = longint'(cfg_freq); ms_duty = int'(cfg_duty); m_pend = 1;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("wave", wave_out, o_wave);
        check("valid", wave_valid, o_v);
        check("sync", sync, o_s);
        check("ready", cfg_ready, !m_pend);
        check("addr", tbl_addr, m_phase >> (PW - AW));
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic offer(input int mode, input longint unsigned freq, input int duty);
        bit r;
        int k;
        cfg_mode = mode[2:0]; cfg_freq = freq[PW-1:0]; cfg_duty = duty[DW-1:0]; cfg_valid = 1;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk); r = cfg_ready;
            @(posedge clk); #1;
            if (r) break;
        end
        cfg_valid = 0;
        check("offer_accepted", k < 5000, 1);
    endtask

    initial begin
        tick(2);
        chk_on = 1;
        @(negedge clk);
        check("rst_wave", wave_out, 0);
        check("rst_valid", wave_valid, 0);
        check("rst_ready", cfg_ready, 1);
        @(posedge clk); #1;
        rst_n = 1; en = 1;
        offer(4, 32'h0100_0000, 0);
        tick(600);
        offer(0, 32'h0400_0000, 0);
        tick(300);
        offer(1, 32'h0080_0000, 0);
        tick(1100);
        offer(2, 32'h0200_0000, 0);
        tick(40);
        offer(3, 32'h0200_0000, 'h40);
        offer(4, 32'h0100_0000, 0);
        tick(300);
        en = 0; tick(10); en = 1;
        tick(50);
        offer(1, 32'h0010_0000, 0);
        tick(3);
        rst_n = 0;
        @(negedge clk);
        check("rst2_pre_ready", cfg_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst2_wave", wave_out, 0);
        check("rst2_valid", wave_valid, 0);
        check("rst2_ready", cfg_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        offer(5, 32'h0100_0000, 0);
        tick(300);
        @(negedge clk);
        check("reserved_zero", wave_out, 0);
        @(posedge clk); #1;
        offer(3, 32'h0100_0000, 0);
        tick(300);
        @(negedge clk);
        check("pwm_duty0_zero", wave_out, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4000; i++) begin
            bit r;
            @(negedge clk); r = cfg_ready;
            @(posedge clk); #1;
            if (cfg_valid && r && rst_n) cfg_valid = 0;
            en = $urandom_range(0, 9) != 0;
            rst_n = $urandom_range(0, 599) != 0;
            if (!cfg_valid && $urandom_range(0, 15) == 0) begin
                cfg_valid = 1;
                cfg_mode = 3'($urandom_range(0, 7));
                cfg_freq = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 10));
                cfg_duty = 8'($urandom);
            end
        end
        rst_n = 1; cfg_valid = 0; en = 1;
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
